// File: rtl/acq_burst_writer_if.sv
// Acquisition-side and DDR3-FIFO-side signal bundle for acq_burst_writer.
// The slave modport is the writer itself; the master modport is its environment.
interface acq_burst_writer_if;
    logic         ddr3_wr_en;
    logic [131:0] acq_dat;
    logic         acq_valid;
    logic [22:0]  fill_start_adr;
    logic [23:0]  expected_burst_count;
    logic         fifo_full;
    logic [127:0] fifo_dat;
    logic [22:0]  fifo_adr;
    logic         fifo_wr;
    logic [23:0]  burst_count;
    logic         fill_done;
    logic         overflow;
    logic         count_err;
    logic         writer_idle;

    modport master (
        output ddr3_wr_en, acq_dat, acq_valid, fill_start_adr,
               expected_burst_count, fifo_full,
        input  fifo_dat, fifo_adr, fifo_wr, burst_count, fill_done,
               overflow, count_err, writer_idle
    );

    modport slave (
        input  ddr3_wr_en, acq_dat, acq_valid, fill_start_adr,
               expected_burst_count, fifo_full,
        output fifo_dat, fifo_adr, fifo_wr, burst_count, fill_done,
               overflow, count_err, writer_idle
    );
endinterface

// File: rtl/acq_burst_writer.sv
// Buffers tagged acquisition words in an 8-deep elastic buffer and writes them
// as consecutive DDR3 bursts, tracking fill completion, overflow and count errors.
module acq_burst_writer (
    input  logic              adc_clk,
    input  logic              reset_clk_adc,
    acq_burst_writer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0]  TAG_TRAILER = 4'hF;
    localparam logic [23:0] BC_MAX      = 24'hFFFFFF;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [131:0]  r_mem [0:7];
    logic [2:0]    r_wptr;
    logic [2:0]    r_rptr;
    logic [3:0]    r_count;
    logic          r_trailer_seen;
    logic [22:0]   r_adr;
    logic          r_fifo_wr;
    logic [127:0]  r_fifo_dat;
    logic [22:0]   r_fifo_adr;
    logic [23:0]   r_burst_count;
    logic          r_fill_done;
    logic          r_overflow;
    logic          r_count_err;
    logic          r_writer_idle;

    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic          w_pop_trailer;
    logic          w_start;
    logic          w_to_done;
    logic          w_to_drain;
    logic [23:0]   w_bc_inc;

    // Buffer handshake: a full buffer still accepts a word when it pops the same cycle.
    always_comb begin
        w_pop         = ((r_state == FILL) || (r_state == DRAIN)) &&
                        (r_count != 4'd0) && !bus.fifo_full;
        w_drop        = (r_state == FILL) && bus.acq_valid &&
                        (r_trailer_seen || ((r_count == 4'd8) && !w_pop));
        w_push        = (r_state == FILL) && bus.acq_valid && !w_drop;
        w_pop_trailer = w_pop && (r_mem[r_rptr][131:128] == TAG_TRAILER);
        w_bc_inc      = (r_burst_count == BC_MAX) ? BC_MAX : (r_burst_count + 24'd1);
    end

    // Next-state logic and transition strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_to_done   = 1'b0;
        w_to_drain  = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.ddr3_wr_en) begin
                    w_state_nxt = FILL;
                    w_start     = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            FILL: begin
                if (w_pop_trailer) begin
                    w_state_nxt = DONE;
                    w_to_done   = 1'b1;
                end else if (!bus.ddr3_wr_en) begin
                    w_state_nxt = DRAIN;
                    w_to_drain  = 1'b1;
                end else begin
                    w_state_nxt = FILL;
                end
            end
            DRAIN: begin
                if (r_count == 4'd0) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = DRAIN;
                end
            end
            DONE: begin
                if (!bus.ddr3_wr_en) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = DONE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge adc_clk) begin
        if (reset_clk_adc) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Buffer storage; emptiness is carried by r_count, so the array needs no reset.
    always_ff @(posedge adc_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= bus.acq_dat;
        end
    end

    // Buffer pointers, occupancy and trailer-accepted flag.
    always_ff @(posedge adc_clk) begin
        if (reset_clk_adc) begin
            r_wptr         <= 3'd0;
            r_rptr         <= 3'd0;
            r_count        <= 4'd0;
            r_trailer_seen <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 3'd1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 3'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 4'd1;
                2'b01:   r_count <= r_count - 4'd1;
                default: r_count <= r_count;
            endcase
            if (w_start) begin
                r_trailer_seen <= 1'b0;
            end else if (w_push && (bus.acq_dat[131:128] == TAG_TRAILER)) begin
                r_trailer_seen <= 1'b1;
            end
        end
    end

    // Write port, address/burst counting and sticky status.
    always_ff @(posedge adc_clk) begin
        if (reset_clk_adc) begin
            r_adr         <= 23'd0;
            r_fifo_wr     <= 1'b0;
            r_fifo_dat    <= 128'd0;
            r_fifo_adr    <= 23'd0;
            r_burst_count <= 24'd0;
            r_fill_done   <= 1'b0;
            r_overflow    <= 1'b0;
            r_count_err   <= 1'b0;
            r_writer_idle <= 1'b1;
        end else begin
            r_fifo_wr     <= w_pop;
            r_fill_done   <= w_to_done;
            r_writer_idle <= (w_state_nxt == IDLE);
            if (w_start) begin
                r_adr         <= bus.fill_start_adr;
                r_burst_count <= 24'd0;
                r_overflow    <= 1'b0;
                r_count_err   <= 1'b0;
            end else begin
                if (w_pop) begin
                    r_fifo_dat    <= r_mem[r_rptr][127:0];
                    r_fifo_adr    <= r_adr;
                    r_adr         <= r_adr + 23'd8;
                    r_burst_count <= w_bc_inc;
                end
                if (w_drop) begin
                    r_overflow <= 1'b1;
                end
                if (w_to_drain || (w_to_done && (w_bc_inc != bus.expected_burst_count))) begin
                    r_count_err <= 1'b1;
                end
            end
        end
    end

    assign bus.fifo_wr     = r_fifo_wr;
    assign bus.fifo_dat    = r_fifo_dat;
    assign bus.fifo_adr    = r_fifo_adr;
    assign bus.burst_count = r_burst_count;
    assign bus.fill_done   = r_fill_done;
    assign bus.overflow    = r_overflow;
    assign bus.count_err   = r_count_err;
    assign bus.writer_idle = r_writer_idle;
endmodule

// File: tb/tb_acq_burst_writer.sv
// Bench for acq_burst_writer: directed scenarios plus randomized fills, all
// checked against a queue-based transaction model of the writer's rules.
module tb_acq_burst_writer;
    logic adc_clk = 1'b0;
    logic reset_clk_adc;
    acq_burst_writer_if bus ();

    acq_burst_writer dut (
        .adc_clk       (adc_clk),
        .reset_clk_adc (reset_clk_adc),
        .bus           (bus)
    );

    always #2 adc_clk = ~adc_clk;

    typedef enum {M_IDLE, M_FILL, M_DRAIN, M_DONE} mode_t;

    int checks   = 0;
    int failures = 0;

    mode_t        mode;
    logic [131:0] mq [$];
    logic [22:0]  m_adr;
    logic [23:0]  m_bc;
    logic         m_ovf, m_cerr, m_trl, m_done, m_wr;
    logic [127:0] m_dat;
    logic [22:0]  m_wadr;
    logic [22:0]  cfg_start;
    logic [23:0]  cfg_expected;

    logic [22:0]  wlog [$];
    logic [127:0] dlog [$];
    logic [127:0] sent [$];
    int           n_done;

    task automatic check_eq(input string tag, input logic [131:0] obs, input logic [131:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        wlog.delete();
        dlog.delete();
        sent.delete();
        n_done = 0;
    endtask

    // One clock: drive inputs, advance the model at the edge, compare on the falling edge.
    task automatic step(input logic rst, input logic wr_en, input logic valid,
                        input logic [131:0] dat, input logic full);
        int           sz;
        bit           popped;
        bit           ptrl;
        logic [131:0] w;
        reset_clk_adc            = rst;
        bus.ddr3_wr_en           = wr_en;
        bus.acq_valid            = valid;
        bus.acq_dat              = dat;
        bus.fifo_full            = full;
        bus.fill_start_adr       = cfg_start;
        bus.expected_burst_count = cfg_expected;
        if (valid) sent.push_back(dat[127:0]);
        @(posedge adc_clk);
        m_wr   = 1'b0;
        m_done = 1'b0;
        popped = 1'b0;
        ptrl   = 1'b0;
        if (rst) begin
            mq.delete();
            mode   = M_IDLE;
            m_adr  = 23'd0;
            m_bc   = 24'd0;
            m_ovf  = 1'b0;
            m_cerr = 1'b0;
            m_trl  = 1'b0;
            m_dat  = 128'd0;
            m_wadr = 23'd0;
        end else begin
            sz = mq.size();
            case (mode)
                M_IDLE: begin
                    if (wr_en) begin
                        mode   = M_FILL;
                        m_adr  = cfg_start;
                        m_bc   = 24'd0;
                        m_ovf  = 1'b0;
                        m_cerr = 1'b0;
                        m_trl  = 1'b0;
                    end
                end
                M_FILL, M_DRAIN: begin
                    if (sz > 0 && !full) begin
                        w      = mq.pop_front();
                        popped = 1'b1;
                        m_wr   = 1'b1;
                        m_dat  = w[127:0];
                        m_wadr = m_adr;
                        m_adr  = m_adr + 23'd8;
                        if (m_bc != 24'hFFFFFF) m_bc = m_bc + 24'd1;
                        ptrl   = (w[131:128] == 4'hF);
                    end
                    if (mode == M_FILL) begin
                        if (valid) begin
                            if (m_trl || mq.size() == 8) begin
                                m_ovf = 1'b1;
                            end else begin
                                mq.push_back(dat);
                                if (dat[131:128] == 4'hF) m_trl = 1'b1;
                            end
                        end
                        if (popped && ptrl) begin
                            mode   = M_DONE;
                            m_done = 1'b1;
                            if (m_bc != cfg_expected) m_cerr = 1'b1;
                        end else if (!wr_en) begin
                            mode   = M_DRAIN;
                            m_cerr = 1'b1;
                        end
                    end else if (sz == 0) begin
                        mode = M_IDLE;
                    end
                end
                M_DONE: begin
                    if (!wr_en) mode = M_IDLE;
                end
                default: mode = M_IDLE;
            endcase
        end
        @(negedge adc_clk);
        check_eq("fifo_wr", bus.fifo_wr, m_wr);
        if (m_wr || rst) begin
            check_eq("fifo_dat", bus.fifo_dat, m_dat);
            check_eq("fifo_adr", bus.fifo_adr, m_wadr);
        end
        check_eq("burst_count", bus.burst_count, m_bc);
        check_eq("fill_done", bus.fill_done, m_done);
        check_eq("overflow", bus.overflow, m_ovf);
        check_eq("count_err", bus.count_err, m_cerr);
        check_eq("writer_idle", bus.writer_idle, mode == M_IDLE);
        if (bus.fifo_wr) begin
            wlog.push_back(bus.fifo_adr);
            dlog.push_back(bus.fifo_dat);
        end
        if (bus.fill_done) n_done++;
    endtask

    function automatic logic [131:0] mkword(input logic [3:0] tag);
        return {tag, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic idle_cycles(input int n, input logic wr_en, input logic full);
        for (int i = 0; i < n; i++) step(1'b0, wr_en, 1'b0, 132'd0, full);
    endtask

    task automatic tagged_fill(input logic [23:0] expected);
        logic [3:0] tags [4];
        tags = '{4'h1, 4'h2, 4'h0, 4'hF};
        cfg_start    = 23'h000100;
        cfg_expected = expected;
        clear_logs();
        step(1'b0, 1'b1, 1'b0, 132'd0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, mkword(tags[i]), 1'b0);
        idle_cycles(4, 1'b1, 1'b0);
        check_eq("tagged_nwr", wlog.size(), 4);
        check_eq("tagged_ndone", n_done, 1);
        check_eq("tagged_cerr", bus.count_err, (expected != 24'd4));
        if (wlog.size() == 4) begin
            check_eq("tagged_adr0", wlog[0], 23'h000100);
            check_eq("tagged_adr3", wlog[3], 23'h000118);
        end
        idle_cycles(2, 1'b0, 1'b0);
    endtask

    initial begin
        logic [3:0] tg;
        int         r;
        int         len;
        cfg_start    = 23'd0;
        cfg_expected = 24'd0;
        clear_logs();

        step(1'b1, 1'b0, 1'b0, 132'd0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 132'd0, 1'b0);
        check_eq("reset_idle", bus.writer_idle, 1'b1);
        check_eq("reset_wr", bus.fifo_wr, 1'b0);

        // Complete fill with matching and with mismatching expected count.
        tagged_fill(24'd4);
        tagged_fill(24'd5);

        // Downstream stalled: nine words, only eight fit.
        cfg_start = 23'h000200;
        clear_logs();
        step(1'b0, 1'b1, 1'b0, 132'd0, 1'b1);
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b1, mkword(4'h0), 1'b1);
        idle_cycles(12, 1'b1, 1'b0);
        check_eq("stall_nwr", wlog.size(), 8);
        check_eq("stall_ovf", bus.overflow, 1'b1);
        check_eq("stall_bc", bus.burst_count, 24'd8);
        for (int i = 0; i < 8 && i < dlog.size(); i++) check_eq("stall_order", dlog[i], sent[i]);
        idle_cycles(3, 1'b0, 1'b0);

        // Address wrap, then enable dropped without trailer.
        cfg_start = 23'h7FFFF8;
        clear_logs();
        step(1'b0, 1'b1, 1'b0, 132'd0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, mkword(4'h0), 1'b0);
        idle_cycles(4, 1'b0, 1'b0);
        check_eq("wrap_nwr", wlog.size(), 3);
        if (wlog.size() == 3) begin
            check_eq("wrap_adr0", wlog[0], 23'h7FFFF8);
            check_eq("wrap_adr1", wlog[1], 23'h000000);
            check_eq("wrap_adr2", wlog[2], 23'h000008);
        end
        check_eq("abort_cerr", bus.count_err, 1'b1);
        check_eq("abort_ndone", n_done, 0);
        check_eq("abort_idle", bus.writer_idle, 1'b1);

        // Reset with five words stuck behind a full downstream FIFO.
        cfg_start = 23'h000040;
        clear_logs();
        step(1'b0, 1'b1, 1'b0, 132'd0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, mkword(4'h0), 1'b1);
        step(1'b1, 1'b1, 1'b0, 132'd0, 1'b1);
        idle_cycles(6, 1'b0, 1'b0);
        check_eq("rst_nwr", wlog.size(), 0);
        check_eq("rst_dat", bus.fifo_dat, 128'd0);
        check_eq("rst_adr", bus.fifo_adr, 23'd0);
        check_eq("rst_bc", bus.burst_count, 24'd0);
        check_eq("rst_ovf", bus.overflow, 1'b0);
        check_eq("rst_cerr", bus.count_err, 1'b0);
        check_eq("rst_idle", bus.writer_idle, 1'b1);

        // Randomized fills with random valid, back-pressure, tags and rare resets.
        for (int f = 0; f < 30; f++) begin
            cfg_start    = {$urandom_range(0, 23'h0FFFFF), 3'b000};
            cfg_expected = 24'($urandom_range(1, 14));
            len          = $urandom_range(8, 40);
            for (int c = 0; c < len; c++) begin
                r = $urandom_range(0, 15);
                if (r == 0)       tg = 4'hF;
                else if (r == 15) tg = 4'h7;
                else              tg = 4'(r % 3);
                step(($urandom_range(0, 199) == 0), 1'b1, ($urandom_range(0, 3) != 0),
                     mkword(tg), ($urandom_range(0, 3) == 0));
            end
            for (int c = 0; c < 16; c++) step(1'b0, 1'b0, 1'b0, 132'd0, ($urandom_range(0, 3) == 0));
            idle_cycles(4, 1'b0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/acq_burst_writer.md
ACQ_BURST_WRITER -- requirements
Module: acq_burst_writer

Interface
REQ-001 SHALL have port adc_clk, input, 1: 400 MHz ADC clock; the only clock.
REQ-002 SHALL have port reset_clk_adc, input, 1: reset, synchronous to adc_clk, active-high.
REQ-003 SHALL have port ddr3_wr_en, input, 1: level; high while writing of triggered events to memory is enabled.
REQ-004 SHALL have port acq_dat, input, 132: [131:128] tag, [127:0] header or ADC data.
REQ-005 SHALL have port acq_valid, input, 1: acq_dat valid this cycle; no back-pressure possible.
REQ-006 SHALL have port fill_start_adr, input, 23: first DDR3 burst address of the fill; 3 LSBs 0.
REQ-007 SHALL have port expected_burst_count, input, 24: bursts the fill must contain, trailer included.
REQ-008 SHALL have port fifo_full, input, 1: downstream DDR3 write FIFO cannot accept.
REQ-009 SHALL have port fifo_dat, output, 128: word to downstream FIFO.
REQ-010 SHALL have port fifo_adr, output, 23: DDR3 burst address of fifo_dat.
REQ-011 SHALL have port fifo_wr, output, 1: write strobe to downstream FIFO.
REQ-012 SHALL have port burst_count, output, 24: bursts written this fill.
REQ-013 SHALL have port fill_done, output, 1: one-cycle pulse at fill completion.
REQ-014 SHALL have port overflow, output, 1: sticky, word dropped this fill.
REQ-015 SHALL have port count_err, output, 1: sticky, fill burst count wrong or fill aborted.
REQ-016 SHALL have port writer_idle, output, 1: state is IDLE.

Function
REQ-017 SHALL use tags: 4'h1 fill header, 4'h2 waveform header, 4'h0 ADC data, 4'hF fill trailer; all others written as data.
REQ-018 SHALL contain an 8-entry, 132-bit elastic buffer between acq_dat and fifo_dat.
REQ-019 SHALL implement states IDLE, FILL, DRAIN, DONE.
REQ-020 IDLE -> FILL when ddr3_wr_en high; same edge loads address register = fill_start_adr, burst_count = 0, clears overflow and count_err.
REQ-021 SHALL push acq_dat only in FILL with acq_valid high; acq_valid ignored in other states.
REQ-022 SHALL pop when buffer not empty and fifo_full low, in FILL or DRAIN.
REQ-023 Pop at cycle N SHALL present fifo_wr=1, fifo_dat=word[127:0], fifo_adr=address at cycle N+1; fifo_wr=0 otherwise.
REQ-024 Minimum latency acq_valid to fifo_wr SHALL be 2 cycles (push N, pop N+1, write N+2).
REQ-025 Each write SHALL advance address by 8, modulo 2^23, and increment burst_count, saturating at 24'hFFFFFF.
REQ-026 Push with buffer full and no same-cycle pop SHALL drop the word and set overflow; push and pop in same cycle when full SHALL both occur.
REQ-027 Writing a tag-4'hF word SHALL move FILL -> DONE; words pushed after the trailer in the same fill SHALL be discarded and set overflow.
REQ-028 On entering DONE, fill_done SHALL pulse one cycle; count_err set if burst_count != expected_burst_count.
REQ-029 DONE -> IDLE when ddr3_wr_en low.
REQ-030 ddr3_wr_en low in FILL before trailer SHALL move to DRAIN and set count_err; DRAIN empties the buffer, then goes to IDLE without fill_done.
REQ-031 fifo_full high SHALL hold all pops; buffer contents and order preserved.

Reset
REQ-032 reset_clk_adc high SHALL force IDLE, empty buffer, fifo_wr=0, fifo_dat=0, fifo_adr=0, burst_count=0, fill_done=0, overflow=0, count_err=0, writer_idle=1.
REQ-033 Reset mid-FILL SHALL discard buffered words with no further fifo_wr.

Verification
REQ-034 fill_start_adr=0x000100, expected=4; ddr3_wr_en high; tags 1,2,0,F consecutive, fifo_full=0 -> 4 writes, adr 0x100,0x108,0x110,0x118, fill_done pulse, count_err=0.
REQ-035 Same fill, expected=5 -> fill_done pulses, count_err=1.
REQ-036 fifo_full held high, 9 consecutive valid words -> first 8 written in order after release, overflow=1, burst_count=8.
REQ-037 fill_start_adr=0x7FFFF8, 3 words -> fifo_adr 0x7FFFF8, 0x000000, 0x000008.
REQ-038 ddr3_wr_en drops after 3 data words, no trailer -> 3 writes complete, count_err=1, no fill_done, writer_idle=1.
REQ-039 reset_clk_adc asserted one cycle with 5 words buffered and fifo_full=1 -> after release fifo_full=0 yields no fifo_wr; all outputs at reset values.
